// File: rtl/rv_emu_retire_cmp_pkg.sv
// Shared definitions for the emulator-vs-CPU retire comparator.
// The RET_REC layout depends on RV_EMU_CMP_CSR_CHECK_EN. When that macro is
// defined, the record also carries the CSR write fields.
package RV_EMU_params_pkg;

    // Number of per-record check flags.
    localparam int CHECKS   = 15;
    // Widest supported XLEN. Record fields are stored zero-extended to this width.
    localparam int MAX_XLEN = 64;

    // Bit positions inside emu_chk. Bits 8..14 are reserved.
    localparam int CHK_PC          = 0;
    localparam int CHK_GPR_WR      = 1;
    localparam int CHK_GPR_ADDR    = 2;
    localparam int CHK_GPR_DATA    = 3;
    localparam int CHK_CSR_WR      = 4;
    localparam int CHK_CSR_WR_DATA = 5;
    localparam int CHK_MODE        = 6;
    localparam int CHK_EXC         = 7;

    // Bit positions inside err_fields, ordered {pc,gpr,csr,mode,exc,underflow}.
    localparam int CMP_ERR_W         = 6;
    localparam int CMP_ERR_UNDERFLOW = 0;
    localparam int CMP_ERR_EXC       = 1;
    localparam int CMP_ERR_MODE      = 2;
    localparam int CMP_ERR_CSR       = 3;
    localparam int CMP_ERR_GPR       = 4;
    localparam int CMP_ERR_PC        = 5;

    // One expected retire record, as supplied by the emulator.
    typedef struct packed {
        logic [MAX_XLEN-1:0] pc;
        logic                gpr_wr;
        logic [4:0]          gpr_addr;
        logic [MAX_XLEN-1:0] gpr_data;
`ifdef RV_EMU_CMP_CSR_CHECK_EN
        logic                csr_wr;
        logic [11:0]         csr_addr;
        logic [MAX_XLEN-1:0] csr_data;
`endif
        logic [1:0]          mode;
        logic                exc;
        logic [CHECKS-1:0]   chk;
    } RET_REC;

    // Saturating 16-bit increment, used for the error counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

endpackage

// File: rtl/rv_emu_ret_fifo.sv
// Expected-record FIFO. DEPTH must be a power of two.
// The head entry is visible at rdata whenever the FIFO is not empty.
// A push and a pop in the same cycle are both performed.
module rv_emu_ret_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         push_ok;
    logic         pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Advance the pointers. The extra MSB tells full apart from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= {(AW+1){1'b0}};
            rd_ptr <= {(AW+1){1'b0}};
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (pop_ok)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Record storage. It needs no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/rv_emu_retire_cmp.sv
// Compares CPU retire events against expected records queued by an emulator.
// Optional feature RV_EMU_CMP_CSR_CHECK_EN: store and compare the CSR write fields.
// When the macro is undefined, the CSR ports exist but are ignored.
module rv_emu_retire_cmp
    import RV_EMU_params_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 8,
    parameter int STOP_ON_ERR = 1
) (
    input  logic                 clk_in,
    input  logic                 reset_in,
    input  logic                 emu_valid,
    output logic                 emu_ready,
    input  logic [XLEN-1:0]      emu_pc,
    input  logic                 emu_gpr_wr,
    input  logic [4:0]           emu_gpr_addr,
    input  logic [XLEN-1:0]      emu_gpr_data,
    input  logic                 emu_csr_wr,
    input  logic [11:0]          emu_csr_addr,
    input  logic [XLEN-1:0]      emu_csr_data,
    input  logic [1:0]           emu_mode,
    input  logic                 emu_exc,
    input  logic [CHECKS-1:0]    emu_chk,
    input  logic                 cpu_valid,
    input  logic [XLEN-1:0]      cpu_pc,
    input  logic                 cpu_gpr_wr,
    input  logic [4:0]           cpu_gpr_addr,
    input  logic [XLEN-1:0]      cpu_gpr_data,
    input  logic                 cpu_csr_wr,
    input  logic [11:0]          cpu_csr_addr,
    input  logic [XLEN-1:0]      cpu_csr_data,
    input  logic [1:0]           cpu_mode,
    input  logic                 cpu_exc,
    input  logic                 clr_err_in,
    output logic                 cmp_done,
    output logic                 mismatch,
    output logic                 underflow,
    output logic                 err_sticky,
    output logic [CMP_ERR_W-1:0] err_fields,
    output logic [XLEN-1:0]      err_pc,
    output logic [31:0]          retire_cnt,
    output logic [15:0]          err_cnt,
    output logic                 halt
);
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [0:0]           state;
    RET_REC               push_rec;
    RET_REC               head_rec;
    logic [$bits(RET_REC)-1:0] head_vec;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 run;
    logic                 push;
    logic                 pop;
    logic                 underflow_ev;
    logic                 err_ev;
    logic                 csr_bad;
    logic [CMP_ERR_W-1:0] fields;
    logic                 chk_unused;

    assign run          = (state == ST_RUN);
    assign emu_ready    = !fifo_full && run;
    assign push         = emu_valid && emu_ready;
    assign pop          = cpu_valid && run && !fifo_empty;
    assign underflow_ev = cpu_valid && run && fifo_empty;
    assign err_ev       = |fields;
    assign halt         = (state == ST_HALT);
    assign head_rec     = head_vec;
    assign chk_unused   = ^head_rec.chk;

    // Pack the incoming emulator fields into a FIFO record.
    always_comb begin
        push_rec          = '0;
        push_rec.pc       = MAX_XLEN'(emu_pc);
        push_rec.gpr_wr   = emu_gpr_wr;
        push_rec.gpr_addr = emu_gpr_addr;
        push_rec.gpr_data = MAX_XLEN'(emu_gpr_data);
`ifdef RV_EMU_CMP_CSR_CHECK_EN
        push_rec.csr_wr   = emu_csr_wr;
        push_rec.csr_addr = emu_csr_addr;
        push_rec.csr_data = MAX_XLEN'(emu_csr_data);
`endif
        push_rec.mode     = emu_mode;
        push_rec.exc      = emu_exc;
        push_rec.chk      = emu_chk;
    end

    rv_emu_ret_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(RET_REC))
    ) u_fifo (
        .clk   (clk_in),
        .rst   (reset_in),
        .push  (push),
        .wdata (push_rec),
        .pop   (pop),
        .rdata (head_vec),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef RV_EMU_CMP_CSR_CHECK_EN
    // The CSR address and data are compared only when the emulator reports a CSR write.
    always_comb begin
        csr_bad = (head_rec.chk[CHK_CSR_WR] && (head_rec.csr_wr != cpu_csr_wr))
               || (head_rec.csr_wr && head_rec.chk[CHK_CSR_WR_DATA]
                   && ((head_rec.csr_addr != cpu_csr_addr)
                       || (head_rec.csr_data != MAX_XLEN'(cpu_csr_data))));
    end
`else
    logic csr_unused;
    assign csr_unused = ^{emu_csr_wr, emu_csr_addr, emu_csr_data,
                          cpu_csr_wr, cpu_csr_addr, cpu_csr_data};

    // The CSR check is compiled out, so the CSR error bit is held at zero.
    always_comb begin
        csr_bad = 1'b0;
    end
`endif

    // Compute this cycle's per-field error vector from the head record and the CPU retire.
    always_comb begin
        fields = {CMP_ERR_W{1'b0}};
        if (underflow_ev) begin
            fields[CMP_ERR_UNDERFLOW] = 1'b1;
        end else if (pop) begin
            fields[CMP_ERR_PC]   = head_rec.chk[CHK_PC] && (head_rec.pc != MAX_XLEN'(cpu_pc));
            fields[CMP_ERR_GPR]  = (head_rec.chk[CHK_GPR_WR] && (head_rec.gpr_wr != cpu_gpr_wr))
                                || (head_rec.gpr_wr && head_rec.chk[CHK_GPR_ADDR]
                                    && (head_rec.gpr_addr != cpu_gpr_addr))
                                || (head_rec.gpr_wr && head_rec.chk[CHK_GPR_DATA]
                                    && (head_rec.gpr_data != MAX_XLEN'(cpu_gpr_data)));
            fields[CMP_ERR_CSR]  = csr_bad;
            fields[CMP_ERR_MODE] = head_rec.chk[CHK_MODE] && (head_rec.mode != cpu_mode);
            fields[CMP_ERR_EXC]  = head_rec.chk[CHK_EXC] && (head_rec.exc != cpu_exc);
        end else begin
            fields = {CMP_ERR_W{1'b0}};
        end
    end

    // Run/halt control. An error takes priority over a clear in the same cycle.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN:  if (err_ev && (STOP_ON_ERR != 0)) state <= ST_HALT;
                ST_HALT: if (clr_err_in) state <= ST_RUN;
                default: state <= ST_RUN;
            endcase
        end
    end

    // Register the compare result, capture error details and update the counters.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            cmp_done   <= 1'b0;
            mismatch   <= 1'b0;
            underflow  <= 1'b0;
            err_sticky <= 1'b0;
            err_fields <= {CMP_ERR_W{1'b0}};
            err_pc     <= {XLEN{1'b0}};
            retire_cnt <= 32'd0;
            err_cnt    <= 16'd0;
        end else begin
            cmp_done  <= pop;
            mismatch  <= pop && err_ev;
            underflow <= underflow_ev;
            if (pop || underflow_ev) err_fields <= fields;
            else if (clr_err_in)     err_fields <= {CMP_ERR_W{1'b0}};
            if (err_ev)          err_sticky <= 1'b1;
            else if (clr_err_in) err_sticky <= 1'b0;
            // Keep the first failing PC until software clears the error.
            if (err_ev && (!err_sticky || clr_err_in)) err_pc <= cpu_pc;
            else if (clr_err_in)                       err_pc <= {XLEN{1'b0}};
            if (err_ev) err_cnt    <= sat_inc16(err_cnt);
            if (pop)    retire_cnt <= retire_cnt + 32'd1;
        end
    end

endmodule

// File: doc/rv_emu_retire_cmp.md
RV_EMU_RETIRE_CMP -- requirements
Module: rv_emu_retire_cmp

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/PC width.
REQ-002 SHALL have parameter DEPTH, default 8, expected-record FIFO depth; power of 2, 2..64.
REQ-003 SHALL have parameter STOP_ON_ERR, default 1; 1 = halt on first mismatch.
REQ-004 SHALL have ports: clk_in in 1, clock; reset_in in 1, synchronous active-high reset.
REQ-005 SHALL have emu_valid in 1 / emu_ready out 1, expected-record handshake.
REQ-006 SHALL have emu_pc in XLEN, emu_gpr_wr in 1, emu_gpr_addr in 5, emu_gpr_data in XLEN.
REQ-007 SHALL have emu_csr_wr in 1, emu_csr_addr in 12, emu_csr_data in XLEN, emu_mode in 2, emu_exc in 1.
REQ-008 SHALL have emu_chk in CHECKS (15), per-record check flags.
REQ-009 SHALL have cpu_valid in 1, CPU retire strobe (no backpressure), plus cpu_pc, cpu_gpr_wr, cpu_gpr_addr, cpu_gpr_data, cpu_csr_wr, cpu_csr_addr, cpu_csr_data, cpu_mode, cpu_exc, widths as emu_*.
REQ-010 SHALL have clr_err_in in 1, clears sticky error and leaves HALT.
REQ-011 SHALL have outputs: cmp_done out 1, mismatch out 1, underflow out 1, err_sticky out 1, err_fields out 6 {pc,gpr,csr,mode,exc,underflow}, err_pc out XLEN, retire_cnt out 32, err_cnt out 16, halt out 1.

Function
REQ-012 SHALL push emu record when emu_valid&&emu_ready; emu_ready = !full && state==RUN.
REQ-013 SHALL pop head when cpu_valid in RUN with FIFO non-empty; push and pop in the same cycle SHALL both occur, occupancy unchanged.
REQ-014 SHALL register compare: cmp_done, mismatch, err_fields valid exactly 1 cycle after the pop cycle.
REQ-015 SHALL compare only flagged fields: pc if chk.pc; gpr_wr/addr/data per chk.gpr_wr/gpr_addr/gpr_data; gpr_addr/data only when emu_gpr_wr=1; csr per chk.csr_wr/csr_wr_data; mode per chk.mode; exc per chk.exceptions.
REQ-016 SHALL treat cpu_valid with FIFO empty (same-cycle emu push not bypassed) as underflow: underflow=1 and err_fields[0]=1 next cycle, no pop.
REQ-017 SHALL on mismatch or underflow: set err_sticky, capture err_pc=cpu_pc (first error only while sticky), increment err_cnt saturating at 16'hFFFF.
REQ-018 SHALL increment retire_cnt on every compared pop, wrapping at 2^32.
REQ-019 SHALL implement states RUN, HALT: RUN->HALT on error when STOP_ON_ERR=1; HALT->RUN on clr_err_in; halt=1 in HALT; cpu_valid ignored in HALT.
REQ-020 SHALL on clr_err_in clear err_sticky, err_fields, err_pc; counters and FIFO contents retained; clr_err_in same cycle as error: error wins.

Reset
REQ-021 SHALL on reset_in: FIFO empty, state RUN, all outputs 0, emu_ready=1 the cycle after reset deasserts; reset mid-operation discards pending records and in-flight compare.

Configuration
REQ-022 SHALL, with RV_EMU_CMP_CSR_CHECK_EN defined, store and compare CSR fields; without it, CSR ports remain but are unused, not stored in FIFO, err_fields[3] tied 0.

Structure
REQ-023 SHALL place RET_REC struct (retire record) and CMP_ERR field-index constants in RV_EMU_params_pkg beside CHECKS.
REQ-024 SHALL use sub-module rv_emu_ret_fifo (parameterised DEPTH, RET_REC width, full/empty, same-cycle push/pop).

Verification
REQ-025 SHALL cover: push 3 matching records, 3 cpu_valid -> retire_cnt=3, mismatch never 1, err_cnt=0.
REQ-026 SHALL cover: cpu_gpr_data=32'h5 vs emu 32'h6, chk.gpr_data=1 -> mismatch=1, err_fields=6'b010000, err_pc=cpu_pc, halt=1 next cycle; same with chk.gpr_data=0 -> no mismatch.
REQ-027 SHALL cover: cpu_valid with empty FIFO and simultaneous emu push -> underflow=1, FIFO occupancy 1 afterward.
REQ-028 SHALL cover: DEPTH pushes -> emu_ready=0; push+pop same cycle at DEPTH-1 -> occupancy stays DEPTH-1.
REQ-029 SHALL cover: STOP_ON_ERR=0, 70000 forced mismatches -> err_cnt=16'hFFFF, err_pc = first failing PC, halt=0.
REQ-030 SHALL cover: reset_in asserted with 4 queued records -> emu_ready=1, retire_cnt=0, next cpu_valid reports underflow.
